// File: rtl/synth_timing_pkg.sv
// Shared timing types and helpers for the synth tick generator.
// Integer math only, so every helper can be used in parameter defaults.
package synth_timing_pkg;

  typedef enum logic {
    IDLE,
    RUN
  } tick_state_e;

  // round(rate * 2^acc_w / clk)
  function automatic longint unsigned tick_inc(
    input longint unsigned rate,
    input longint unsigned clk,
    input int              acc_w
  );
    return ((rate << acc_w) + clk / 2) / clk;
  endfunction

  function automatic int frame_len(
    input int voices,
    input int envs
  );
    return voices * envs;
  endfunction

endpackage

// File: rtl/synth_tick_gen_phase_tick.sv
// Fractional phase accumulator. The tick output is the raw carry-out
// of this cycle's add; the parent registers it into a strobe.
module phase_tick #(
  parameter int              ACC_W = 32,
  parameter longint unsigned INC   = 1
) (
  input  logic AUDIO_CLK,
  input  logic reset_reg_N,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam logic [ACC_W-1:0] INC_W = ACC_W'(INC);

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;
  logic [ACC_W-1:0] sum;
  logic             carry;

  // clr wins over en so the carry of the last add still escapes
  always_comb begin
    {carry, sum} = {1'b0, acc_q} + {1'b0, INC_W};
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = sum;
    end
    tick = en & carry;
  end

  always_ff @(posedge AUDIO_CLK or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/synth_tick_gen.sv
// Tick generator: trigger edge detect, IDLE/RUN sequencer,
// voice x envelope index counter and sticky overrun flag.
module synth_tick_gen
  import synth_timing_pkg::*;
#(
  parameter int              VOICES  = 8,
  parameter int              V_OSC   = 4,
  parameter int              V_ENVS  = 2 * V_OSC,
  parameter int              V_WIDTH = 3,
  parameter int              E_WIDTH = 3,
  parameter int              ACC_W   = 32,
  parameter longint unsigned AUDIO_CLK_RATE = 90416666,
  parameter longint unsigned SAMPLE_RATE    = 44100,
  parameter longint unsigned ENV_INC = tick_inc(
    SAMPLE_RATE * 64'(VOICES * V_ENVS * 4),
    AUDIO_CLK_RATE, ACC_W),
  parameter longint unsigned OSC_INC = tick_inc(
    SAMPLE_RATE * 64'(VOICES * V_OSC * 4),
    AUDIO_CLK_RATE, ACC_W)
) (
  input  logic                       AUDIO_CLK,
  input  logic                       reset_reg_N,
  input  logic                       trig,
  input  logic                       free_run,
  input  logic                       clr_overrun,
  output logic                       osc_tick,
  output logic                       env_tick,
  output logic [V_WIDTH+E_WIDTH-1:0] xxxx,
  output logic                       xxxx_zero,
  output logic                       frame_done,
  output logic                       busy,
  output logic                       overrun
);

  localparam int XW   = V_WIDTH + E_WIDTH;
  localparam int FLEN = frame_len(VOICES, V_ENVS);
  localparam logic [XW-1:0] LAST = XW'(FLEN - 1);
  localparam longint unsigned ACC_MOD = 64'd1 << ACC_W;

  if (ACC_W < 8 || ACC_W > 32) begin : g_bad_acc_w
    $error("ACC_W must be 8..32");
  end
  if (FLEN < 2 || FLEN > (1 << XW)) begin : g_bad_frame_len
    $error("frame length does not fit the index counter");
  end
  if (ENV_INC < 1 || ENV_INC >= ACC_MOD) begin : g_bad_env_inc
    $error("ENV_INC out of range");
  end
  if (OSC_INC < 1 || OSC_INC >= ACC_MOD) begin : g_bad_osc_inc
    $error("OSC_INC out of range");
  end

  tick_state_e   state_q, state_d;
  logic          trig_q;
  logic [XW-1:0] xxxx_q, xxxx_d;
  logic          zero_q, zero_d;
  logic          done_q, done_d;
  logic          ovr_q, ovr_d;
  logic          env_tk_q, osc_tk_q;
  logic          env_c, osc_c;
  logic          run, clr, trig_rise, wrap;

  assign run = (state_q == RUN);
  assign clr = (state_d == IDLE);

  phase_tick #(.ACC_W(ACC_W), .INC(ENV_INC)) u_env (
    .AUDIO_CLK   (AUDIO_CLK),
    .reset_reg_N (reset_reg_N),
    .en          (run),
    .clr         (clr),
    .tick        (env_c)
  );

  phase_tick #(.ACC_W(ACC_W), .INC(OSC_INC)) u_osc (
    .AUDIO_CLK   (AUDIO_CLK),
    .reset_reg_N (reset_reg_N),
    .en          (run),
    .clr         (clr),
    .tick        (osc_c)
  );

  always_comb begin
    trig_rise = trig & ~trig_q;
    wrap      = env_c && (xxxx_q == LAST);
    state_d   = state_q;
    xxxx_d    = xxxx_q;
    ovr_d     = ovr_q & ~clr_overrun;
    unique case (state_q)
      IDLE: begin
        if (trig_rise || free_run) state_d = RUN;
      end
      RUN: begin
        if (env_c) xxxx_d = wrap ? '0 : xxxx_q + XW'(1);
        if (wrap && !free_run && !trig_rise) state_d = IDLE;
        if (trig_rise && !wrap) ovr_d = 1'b1;
      end
    endcase
    zero_d = (xxxx_d == '0);
    done_d = wrap;
  end

  always_ff @(posedge AUDIO_CLK or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      state_q  <= IDLE;
      trig_q   <= 1'b0;
      xxxx_q   <= '0;
      zero_q   <= 1'b1;
      done_q   <= 1'b0;
      ovr_q    <= 1'b0;
      env_tk_q <= 1'b0;
      osc_tk_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      trig_q   <= trig;
      xxxx_q   <= xxxx_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
      ovr_q    <= ovr_d;
      env_tk_q <= env_c;
      osc_tk_q <= osc_c;
    end
  end

  assign osc_tick   = osc_tk_q;
  assign env_tick   = env_tk_q;
  assign xxxx       = xxxx_q;
  assign xxxx_zero  = zero_q;
  assign frame_done = done_q;
  assign busy       = run;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_synth_tick_gen.sv
// Bench for synth_tick_gen: expected tick events are queued when a
// frame is launched and matched as the strobes appear.
module tb_synth_tick_gen;

  localparam int XW = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic trig = 1'b0;
  logic free_run = 1'b0;
  logic clr_ovr = 1'b0;
  logic osc_tick, env_tick, xz, fd, busy, ovr;
  logic [XW-1:0] xxxx;

  logic fr_f = 1'b0;
  logic f_osc, f_env, f_xz, f_fd, f_busy, f_ovr;
  logic [XW-1:0] f_x;

  always #5 clk = ~clk;

  synth_tick_gen #(
    .VOICES(2), .V_ENVS(2), .ACC_W(8),
    .ENV_INC(64), .OSC_INC(32)
  ) dut (
    .AUDIO_CLK(clk), .reset_reg_N(rst_n),
    .trig(trig), .free_run(free_run),
    .clr_overrun(clr_ovr),
    .osc_tick(osc_tick), .env_tick(env_tick),
    .xxxx(xxxx), .xxxx_zero(xz),
    .frame_done(fd), .busy(busy),
    .overrun(ovr)
  );

  synth_tick_gen #(
    .VOICES(2), .V_ENVS(2), .ACC_W(8),
    .ENV_INC(3), .OSC_INC(5)
  ) dut_frac (
    .AUDIO_CLK(clk), .reset_reg_N(rst_n),
    .trig(1'b0), .free_run(fr_f),
    .clr_overrun(1'b0),
    .osc_tick(f_osc), .env_tick(f_env),
    .xxxx(f_x), .xxxx_zero(f_xz),
    .frame_done(f_fd), .busy(f_busy),
    .overrun(f_ovr)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_err = 0;
  int n_chk = 0;

  task automatic chk(input string tag,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  typedef struct {
    int at;
    int x;
    int fd;
  } ev_t;

  ev_t env_q[$];
  int  osc_q[$];
  int  frac_q[$];
  bit  mon_en = 1'b0;
  bit  frac_en = 1'b0;
  int  frac_lo, frac_hi;
  int  frac_cnt = 0;
  int  frac_last = 0;

  task automatic push_frame(input int n);
    ev_t e;
    for (int k = 1; k <= 4; k++) begin
      e.at = n + 4 * k;
      e.x  = k % 4;
      e.fd = (k == 4) ? 1 : 0;
      env_q.push_back(e);
    end
    osc_q.push_back(n + 8);
    osc_q.push_back(n + 16);
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, "_env_left"}, env_q.size(), 0);
    chk({tag, "_osc_left"}, osc_q.size(), 0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_xxxx"}, xxxx, 0);
    chk({tag, "_xz"}, xz, 1);
    chk({tag, "_env"}, env_tick, 0);
    chk({tag, "_osc"}, osc_tick, 0);
    chk({tag, "_fd"}, fd, 0);
    chk({tag, "_ovr"}, ovr, 0);
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (mon_en) begin
      if (env_tick) begin
        if (env_q.size() == 0) begin
          chk("env_extra", cyc, -1);
        end else begin
          e = env_q.pop_front();
          chk("env_cyc", cyc, e.at);
          chk("xxxx", xxxx, e.x);
          chk("frame_done", fd, e.fd);
          chk("xxxx_zero", xz, (e.x == 0) ? 1 : 0);
        end
      end
      if (fd && !env_tick) chk("fd_stray", fd, 0);
      if (osc_tick) begin
        if (osc_q.size() == 0) chk("osc_extra", cyc, -1);
        else chk("osc_cyc", cyc, osc_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (frac_en && f_env && cyc >= frac_lo && cyc <= frac_hi) begin
      frac_cnt++;
      if (frac_q.size() == 0) chk("frac_extra", cyc, -1);
      else chk("frac_cyc", cyc, frac_q.pop_front());
      if (frac_last > 0)
        chk("frac_gap", (cyc - frac_last == 85) ||
                        (cyc - frac_last == 86), 1);
      frac_last = cyc;
    end
  end

  initial begin
    int n;
    int acc;
    repeat (3) @(negedge clk);
    chk_reset("rst");
    rst_n = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;

    // one-shot
    trig = 1'b1;
    n = cyc + 1;
    push_frame(n);
    @(negedge clk);
    chk("os_busy_rise", busy, 1);
    wait_to(n + 15);
    chk("os_busy_hold", busy, 1);
    wait_to(n + 16);
    chk("os_busy_fall", busy, 0);
    wait_to(n + 30);
    chk_empty("os");
    trig = 1'b0;
    @(negedge clk);

    // free-run, dropped during the second frame
    free_run = 1'b1;
    n = cyc + 1;
    push_frame(n);
    push_frame(n + 16);
    wait_to(n + 18);
    chk("fr_busy", busy, 1);
    free_run = 1'b0;
    wait_to(n + 31);
    chk("fr_busy_late", busy, 1);
    wait_to(n + 32);
    chk("fr_stop", busy, 0);
    wait_to(n + 45);
    chk_empty("fr");

    // overrun
    trig = 1'b1;
    n = cyc + 1;
    push_frame(n);
    wait_to(n + 2);
    trig = 1'b0;
    wait_to(n + 5);
    chk("ovr_pre", ovr, 0);
    trig = 1'b1;
    wait_to(n + 6);
    chk("ovr_set", ovr, 1);
    wait_to(n + 16);
    chk("ovr_len", busy, 0);
    chk("ovr_hold", ovr, 1);
    clr_ovr = 1'b1;
    @(negedge clk);
    clr_ovr = 1'b0;
    chk("ovr_clr", ovr, 0);
    trig = 1'b0;
    @(negedge clk);
    trig = 1'b1;
    n = cyc + 1;
    push_frame(n);
    wait_to(n + 2);
    trig = 1'b0;
    wait_to(n + 5);
    trig = 1'b1;
    clr_ovr = 1'b1;
    wait_to(n + 6);
    clr_ovr = 1'b0;
    chk("ovr_set_wins", ovr, 1);
    wait_to(n + 17);
    clr_ovr = 1'b1;
    @(negedge clk);
    clr_ovr = 1'b0;
    chk("ovr_clr2", ovr, 0);
    trig = 1'b0;
    wait_to(n + 25);
    chk_empty("ovr");

    // back-to-back
    trig = 1'b1;
    n = cyc + 1;
    push_frame(n);
    push_frame(n + 16);
    wait_to(n + 2);
    trig = 1'b0;
    wait_to(n + 15);
    trig = 1'b1;
    wait_to(n + 16);
    chk("b2b_busy", busy, 1);
    chk("b2b_ovr", ovr, 0);
    wait_to(n + 32);
    chk("b2b_end", busy, 0);
    wait_to(n + 40);
    chk_empty("b2b");
    trig = 1'b0;
    @(negedge clk);

    // reset mid-frame
    trig = 1'b1;
    n = cyc + 1;
    push_frame(n);
    wait_to(n + 8);
    chk("mid_xxxx", xxxx, 2);
    #2;
    rst_n = 1'b0;
    trig = 1'b0;
    #1;
    chk_reset("async");
    env_q.delete();
    osc_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n = cyc;
    wait_to(n + 20);
    chk("rst_idle", busy, 0);
    trig = 1'b1;
    n = cyc + 1;
    push_frame(n);
    wait_to(n + 1);
    chk("rst_retrig", busy, 1);
    wait_to(n + 25);
    chk_empty("rst");
    trig = 1'b0;

    // fractional rate on the second instance
    fr_f = 1'b1;
    n = cyc + 1;
    acc = 0;
    for (int j = 1; j <= 25600; j++) begin
      acc += 3;
      if (acc >= 256) begin
        acc -= 256;
        frac_q.push_back(n + j);
      end
    end
    frac_lo = n + 1;
    frac_hi = n + 25600;
    frac_en = 1'b1;
    wait_to(n + 25601);
    frac_en = 1'b0;
    chk("frac_count", frac_cnt, 300);
    chk("frac_left", frac_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
